// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: operands arrive as two beats on inBus,
// the 2*WIDTH-bit product leaves as two beats (low half, then high half).
module booth_radix4_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signedMode,
    input  logic [WIDTH-1:0] inBus,
    output logic             busy,
    output logic             done,
    output logic             outHi,
    output logic [WIDTH-1:0] outBus
);

    localparam int NSTEPS = WIDTH / 2 + 1;
    localparam int CW     = $clog2(NSTEPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOADY,
        CALC,
        OUTLO,
        OUTHI
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]          x;
    logic [WIDTH+1:0]          y;
    logic signed [WIDTH+2:0]   acc;
    logic                      y_m1;
    logic                      mode;
    logic [CW-1:0]             cnt;

    logic [WIDTH+1:0]          x_ext;
    logic signed [WIDTH+2:0]   x1;
    logic signed [WIDTH+2:0]   x2;
    logic signed [WIDTH+2:0]   addend;
    logic signed [WIDTH+2:0]   sum;
    logic signed [2*WIDTH+5:0] shifted;
    logic [2*WIDTH-1:0]        prod;
    logic                      unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOADY;
            LOADY:   state_nxt = CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = OUTLO;
            OUTLO:   state_nxt = OUTHI;
            OUTHI:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One Booth step: add the recoded multiple, then shift {A, Y, Y-1} by two.
    always_comb begin
        x_ext  = {{2{mode & x[WIDTH-1]}}, x};
        x1     = {x_ext[WIDTH+1], x_ext};
        x2     = {x_ext, 1'b0};
        addend = '0;
        case ({y[1:0], y_m1})
            3'b001, 3'b010: addend = x1;
            3'b011:         addend = x2;
            3'b100:         addend = -x2;
            3'b101, 3'b110: addend = -x1;
            default:        addend = '0;
        endcase
        sum     = acc + addend;
        shifted = $signed({sum, y, y_m1}) >>> 2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x    <= '0;
            y    <= '0;
            acc  <= '0;
            y_m1 <= 1'b0;
            mode <= 1'b0;
            cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) x <= inBus;
                end
                LOADY: begin
                    y    <= {{2{signedMode & inBus[WIDTH-1]}}, inBus};
                    mode <= signedMode;
                    acc  <= '0;
                    y_m1 <= 1'b0;
                    cnt  <= CW'(NSTEPS);
                end
                CALC: begin
                    acc  <= shifted[2*WIDTH+5:WIDTH+3];
                    y    <= shifted[WIDTH+2:1];
                    y_m1 <= shifted[0];
                    cnt  <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // After NSTEPS double shifts the exact product sits across {A, Y}.
    assign prod        = {acc[WIDTH-3:0], y};
    assign unused_bits = ^acc[WIDTH+2:WIDTH-2];

    assign busy   = (state != IDLE);
    assign done   = (state == OUTLO) || (state == OUTHI);
    assign outHi  = (state == OUTHI);
    assign outBus = (state == OUTLO) ? prod[WIDTH-1:0] :
                    (state == OUTHI) ? prod[2*WIDTH-1:WIDTH] :
                    '0;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Randomized and directed bench for booth_radix4_multiplier at WIDTH 8 and 4,
// checked against a plain-integer product model.
module tb_booth_radix4_multiplier;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic       sm8 = 1'b0;
    logic [7:0] bus8 = '0;
    logic       busy8;
    logic       done8;
    logic       hi8;
    logic [7:0] out8;

    logic       start4 = 1'b0;
    logic       sm4 = 1'b0;
    logic [3:0] bus4 = '0;
    logic       busy4;
    logic       done4;
    logic       hi4;
    logic [3:0] out4;

    int n_total = 0;
    int n_bad = 0;

    booth_radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .signedMode (sm8),
        .inBus      (bus8),
        .busy       (busy8),
        .done       (done8),
        .outHi      (hi8),
        .outBus     (out8)
    );

    booth_radix4_multiplier #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .signedMode (sm4),
        .inBus      (bus4),
        .busy       (busy4),
        .done       (done4),
        .outHi      (hi4),
        .outBus     (out4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic longint opnd(input logic [7:0] v, input int w,
                                    input logic sm);
        longint r = 0;
        for (int i = 0; i < w; i++)
            if (v[i]) r += (longint'(1) << i);
        if (sm && v[w-1]) r -= (longint'(1) << w);
        return r;
    endfunction

    // Start accepted in cycle 0; done expected in cycles 7 and 8.
    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input logic sm, input bit hold);
        longint     p;
        logic [7:0] lo;
        logic [7:0] hi;
        p  = opnd(x, 8, sm) * opnd(y, 8, sm);
        lo = 8'(p);
        hi = 8'(p >> 8);
        @(negedge clk);
        check("w8_idle_busy", busy8, 0);
        check("w8_idle_done", done8, 0);
        start8 = 1'b1;
        bus8   = x;
        sm8    = ~sm;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("w8_busy", busy8, 1);
            check("w8_done", done8, c >= 7);
            check("w8_outhi", hi8, c == 8);
            check("w8_out", out8, c == 7 ? lo : c == 8 ? hi : 8'h00);
            bus8   = (c == 1) ? y : 8'($urandom);
            sm8    = (c == 1) ? sm : 1'($urandom);
            start8 = hold;
        end
    endtask

    // WIDTH 4: N = 3, done expected in cycles 5 and 6.
    task automatic op4(input logic [3:0] x, input logic [3:0] y,
                       input logic sm);
        longint     p;
        logic [3:0] lo;
        logic [3:0] hi;
        p  = opnd({4'h0, x}, 4, sm) * opnd({4'h0, y}, 4, sm);
        lo = 4'(p);
        hi = 4'(p >> 4);
        @(negedge clk);
        check("w4_idle_busy", busy4, 0);
        start4 = 1'b1;
        bus4   = x;
        sm4    = ~sm;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("w4_busy", busy4, 1);
            check("w4_done", done4, c >= 5);
            check("w4_outhi", hi4, c == 6);
            check("w4_out", out4, c == 5 ? lo : c == 6 ? hi : 4'h0);
            bus4   = (c == 1) ? y : 4'($urandom);
            sm4    = (c == 1) ? sm : 1'($urandom);
            start4 = 1'b0;
        end
    endtask

    initial begin
        #1;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_out8", out8, 0);
        check("rst_hi8", hi8, 0);
        check("rst_busy4", busy4, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        op8(8'h80, 8'h80, 1'b1, 1'b0);
        op8(8'hFF, 8'hFF, 1'b0, 1'b0);
        op8(8'h07, 8'hFD, 1'b1, 1'b0);
        op8(8'h07, 8'hFD, 1'b0, 1'b0);

        op8(8'h9C, 8'h3B, 1'b1, 1'b1);
        op8(8'h2D, 8'hE1, 1'b0, 1'b0);

        @(negedge clk);
        start8 = 1'b1;
        bus8   = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        bus8   = 8'h66;
        sm8    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        #2 rst = 1'b0;
        #1;
        check("async_busy", busy8, 0);
        check("async_done", done8, 0);
        check("async_out", out8, 0);
        check("async_hi", hi8, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_done", done8, 0);
            check("post_rst_busy", busy8, 0);
        end
        op8(8'h03, 8'h05, 1'b0, 1'b0);

        op4(4'h8, 4'h7, 1'b1);
        op4(4'hF, 4'hF, 1'b0);
        op4(4'h8, 4'h8, 1'b1);

        repeat (30)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        start8 = 1'b0;
        repeat (15)
            op4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_radix4_multiplier.md
BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have ports in this order:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  begin operation; sampled only in IDLE.
- signedMode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Y.
- inBus  input  WIDTH  operand bus; X then Y on consecutive cycles.
- busy  output  1  high from the cycle after start is accepted until IDLE is re-entered.
- done  output  1  high while result beats are on outBus.
- outHi  output  1  during done: 0 = low half of product, 1 = high half.
- outBus  output  WIDTH  result beat; zero when done = 0.

Function
REQ-003 SHALL implement FSM states IDLE, LOADY, CALC, OUTLO, OUTHI.
REQ-004 In IDLE with start = 1, SHALL capture X <= inBus at that edge and move to LOADY.
REQ-005 In LOADY, SHALL capture Y <= inBus and mode <= signedMode, clear the accumulator, clear the appended Booth bit Y[-1], load the iteration counter with N = WIDTH/2 + 1, and move to CALC.
REQ-006 Operands SHALL be extended to WIDTH+2 bits: sign-extended if mode = 1, zero-extended if mode = 0.
REQ-007 Each CALC cycle SHALL perform exactly one radix-4 Booth step. The step decodes triplet {Y1, Y0, Y-1}: 000/111 -> +0, 001/010 -> +X, 011 -> +2X, 100 -> -2X, 101/110 -> -X. The accumulator is WIDTH+3 bits. The step then arithmetic-shifts {A, Y, Y-1} right by 2 and decrements the counter.
REQ-008 CALC SHALL last exactly N cycles, then move to OUTLO.
REQ-009 The final product P SHALL be exact: 2*WIDTH bits, equal to X*Y interpreted per mode; no overflow is possible.
REQ-010 OUTLO: SHALL drive done = 1, outHi = 0, outBus = P[WIDTH-1:0]; next state OUTHI.
REQ-011 OUTHI: SHALL drive done = 1, outHi = 1, outBus = P[2*WIDTH-1:WIDTH]; next state IDLE.
REQ-012 Latency: if start is accepted in cycle 0, done SHALL be high in cycles N+2 and N+3. For WIDTH = 8 these are cycles 7 and 8.
REQ-013 start SHALL be ignored in every state except IDLE; a new start may be accepted in the first IDLE cycle after OUTHI.
REQ-014 inBus SHALL be ignored outside the IDLE-accept and LOADY cycles; signedMode SHALL be ignored outside LOADY.
REQ-015 done, outHi and outBus SHALL be decoded from registered state and result only, with no combinational path from any input.
REQ-016 busy SHALL be 1 in LOADY, CALC, OUTLO and OUTHI, and 0 in IDLE.

Reset
REQ-017 rst = 0 SHALL immediately, without waiting for a clock edge, force: state IDLE; X, Y, accumulator, counter and Y-1 to 0; busy = 0, done = 0, outHi = 0, outBus = 0.
REQ-018 Reset asserted mid-operation, in any state, SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-019 After rst returns to 1, the first start SHALL be accepted on the first rising edge at which start = 1.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, all at WIDTH = 8:
- signed, X = 0x80 (-128), Y = 0x80 -> beats 0x00 (outHi = 0) then 0x40 (outHi = 1); done in cycles 7 and 8.
- unsigned, X = 0xFF, Y = 0xFF -> beats 0x01 then 0xFE (65025).
- signed, X = 0x07, Y = 0xFD (-3) -> beats 0xEB then 0xFF (-21); unsigned with the same operands -> 0xEB then 0x06 (1771).
- start held high through a whole operation, with inBus changing every cycle -> only the first operands are used; the second operation's X is captured in the IDLE cycle after OUTHI.
- rst = 0 asserted asynchronously during CALC -> busy and done drop to 0 before the next edge; no beats appear afterwards; a fresh 3*5 unsigned operation then returns 0x0F, 0x00.
- WIDTH = 4 instance, signed, 0x8 * 0x7 -> N = 3; beats 0x8 then 0xC (-56).
